// File: rtl/line_mem_responder.sv
// Unified cache-line backing memory: accepts one line read or write at a time and
// completes it with a single rdy pulse a fixed LATENCY cycles after acceptance.
module line_mem_responder #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 64,
    parameter int LATENCY = 4,
    parameter int DEPTH_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              re,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              rdy,
    output logic              busy
);

    // state  | meaning
    // S_IDLE | waiting for re/we; request captured on the accepting edge
    // S_BUSY | latency countdown on the captured request
    // S_DONE | rdy cycle; re/we ignored, back to idle on the next edge
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);
    localparam bit         LAT_ONE = (LATENCY == 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("line_mem_responder: LATENCY=%0d outside 1..15", LATENCY);
    end
    if (DEPTH_W > ADDR_W) begin : g_bad_depth
        $error("line_mem_responder: DEPTH_W=%0d exceeds ADDR_W=%0d", DEPTH_W, ADDR_W);
    end

    logic [1:0]         state;
    logic [3:0]         count;
    logic [DEPTH_W-1:0] cap_addr;
    logic [DATA_W-1:0]  cap_wdata;
    logic               cap_we;

    logic [DATA_W-1:0]  mem [0:(1 << DEPTH_W) - 1];

    logic               mem_en;
    logic               mem_wr;
    logic [DEPTH_W-1:0] mem_a;
    logic [DATA_W-1:0]  mem_d;

    // The array access happens on the edge entering DONE; with LATENCY=1 that is
    // the accepting edge itself, so the live bus is used instead of the capture.
    always_comb begin
        mem_en = 1'b0;
        mem_wr = cap_we;
        mem_a  = cap_addr;
        mem_d  = cap_wdata;
        if (rst_n) begin
            if (LAT_ONE && state == S_IDLE && (re || we)) begin
                mem_en = 1'b1;
                mem_wr = we;
                mem_a  = addr[DEPTH_W-1:0];
                mem_d  = wdata;
            end else if (state == S_BUSY && count == 4'd1) begin
                mem_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_en && mem_wr) begin
            mem[mem_a] <= mem_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && (re || we)) begin
            cap_addr  <= addr[DEPTH_W-1:0];
            cap_wdata <= wdata;
            cap_we    <= we;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            count   <= 4'd0;
            rdy     <= 1'b0;
            busy    <= 1'b0;
            rd_data <= '0;
        end else begin
            if (mem_en && !mem_wr) begin
                rd_data <= mem[mem_a];
            end
            case (state)
                S_IDLE: begin
                    rdy  <= 1'b0;
                    busy <= 1'b0;
                    if (re || we) begin
                        count <= LAT_M1;
                        busy  <= 1'b1;
                        if (LAT_ONE) begin
                            state <= S_DONE;
                            rdy   <= 1'b1;
                        end else begin
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state <= S_DONE;
                        rdy   <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    rdy   <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    rdy   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: a default instance (LATENCY=4) and a LATENCY=1,
// DEPTH_W=4 instance, checked against a line-indexed memory model.
module tb_line_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] addr0 = '0, addr1 = '0;
    logic        re0 = 1'b0, we0 = 1'b0, re1 = 1'b0, we1 = 1'b0;
    logic [63:0] wd0 = '0, wd1 = '0;
    logic [63:0] rd0, rd1;
    logic        rdy0, rdy1, busy0, busy1;

    always #5 clk = ~clk;

    line_mem_responder dut0 (
        .clk(clk), .rst_n(rst_n), .addr(addr0), .re(re0), .we(we0), .wdata(wd0),
        .rd_data(rd0), .rdy(rdy0), .busy(busy0)
    );

    line_mem_responder #(.LATENCY(1), .DEPTH_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .addr(addr1), .re(re1), .we(we1), .wdata(wd1),
        .rd_data(rd1), .rdy(rdy1), .busy(busy1)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] m0 [int];
    logic [63:0] m1 [int];
    logic [13:0] wq0 [$];
    logic [13:0] wq1 [$];
    logic [63:0] last_rd [2];

    typedef struct {
        int          sel;
        logic        r;
        logic        w;
        logic [13:0] a;
        logic [63:0] d;
        int          hold;
        logic        exp_v;
        logic [63:0] exp_d;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, k, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic r, input logic w, input logic [13:0] a,
                         input logic [63:0] d);
        if (sel == 0) begin
            re0 = r; we0 = w; addr0 = a; wd0 = d;
        end else begin
            re1 = r; we1 = w; addr1 = a; wd1 = d;
        end
    endtask

    // hold: 0 = request for one cycle, then bus scrambled; 1 = held through rdy cycle;
    // 2 = held one cycle past rdy, so a second identical request is accepted.
    task automatic txn(input int sel, input logic r, input logic w, input logic [13:0] a,
                       input logic [63:0] d, input int hold, input logic exp_v,
                       input logic [63:0] exp_d);
        int lat, drop_k, nlast, idx;
        bit two, er, eb;
        lat    = (sel != 0) ? 1 : 4;
        drop_k = (hold == 0) ? 1 : (hold == 1) ? lat + 1 : lat + 2;
        two    = (hold == 2);
        nlast  = two ? 2 * lat + 2 : lat + 1;
        idx    = (sel != 0) ? int'(a[3:0]) : int'(a);
        @(negedge clk);
        drive(sel, r, w, a, d);
        for (int k = 1; k <= nlast; k++) begin
            @(negedge clk);
            er = (k == lat) || (two && k == 2 * lat + 1);
            eb = (k >= 1 && k <= lat) || (two && k >= lat + 2 && k <= 2 * lat + 1);
            if (er) begin
                if (w) begin
                    if (sel != 0) m1[idx] = d; else m0[idx] = d;
                end else begin
                    last_rd[sel] = (sel != 0) ? m1[idx] : m0[idx];
                end
            end
            chk("rdy", k, 64'((sel != 0) ? rdy1 : rdy0), 64'(er));
            chk("busy", k, 64'((sel != 0) ? busy1 : busy0), 64'(eb));
            chk("rd_data", k, (sel != 0) ? rd1 : rd0, last_rd[sel]);
            if (exp_v && er) chk("vec_rd_data", k, (sel != 0) ? rd1 : rd0, exp_d);
            if (k == drop_k) drive(sel, 1'b0, 1'b0, two ? a : 14'($urandom), {$urandom, $urandom});
        end
        drive(sel, 1'b0, 1'b0, 14'($urandom), {$urandom, $urandom});
    endtask

    initial begin
        vec_t v;
        int sel, hold, i;
        logic r, w;
        logic [13:0] a;
        logic [63:0] d;

        vt[0] = '{0, 1'b0, 1'b1, 14'h0123, 64'hDEAD_BEEF_0123_4567, 0, 1'b0, 64'h0};
        vt[1] = '{0, 1'b1, 1'b0, 14'h0123, 64'h0, 0, 1'b1, 64'hDEAD_BEEF_0123_4567};
        vt[2] = '{0, 1'b1, 1'b0, 14'h0123, 64'h0, 1, 1'b1, 64'hDEAD_BEEF_0123_4567};
        vt[3] = '{0, 1'b1, 1'b0, 14'h0123, 64'h0, 2, 1'b1, 64'hDEAD_BEEF_0123_4567};
        vt[4] = '{0, 1'b1, 1'b1, 14'h0010, 64'h1111_2222_3333_4444, 0, 1'b0, 64'h0};
        vt[5] = '{0, 1'b1, 1'b0, 14'h0010, 64'h0, 0, 1'b1, 64'h1111_2222_3333_4444};
        vt[6] = '{1, 1'b0, 1'b1, 14'h0013, 64'hA5A5_5A5A_0F0F_F0F0, 0, 1'b0, 64'h0};
        vt[7] = '{1, 1'b1, 1'b0, 14'h0003, 64'h0, 0, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0};
        vt[8] = '{1, 1'b1, 1'b0, 14'h0003, 64'h0, 2, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0};
        last_rd[0] = '0;
        last_rd[1] = '0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_rdy0", k, 64'(rdy0), 64'h0);
            chk("idle_busy0", k, 64'(busy0), 64'h0);
            chk("idle_rd0", k, rd0, 64'h0);
            chk("idle_rdy1", k, 64'(rdy1), 64'h0);
            chk("idle_busy1", k, 64'(busy1), 64'h0);
            chk("idle_rd1", k, rd1, 64'h0);
        end

        for (int n = 0; n < 9; n++) begin
            v = vt[n];
            txn(v.sel, v.r, v.w, v.a, v.d, v.hold, v.exp_v, v.exp_d);
            if (v.w) begin
                if (v.sel != 0) wq1.push_back(v.a); else wq0.push_back(v.a);
            end
        end

        // Reset two cycles into a write: the write must never land.
        txn(0, 1'b0, 1'b1, 14'h0020, 64'h0BAD_F00D_CAFE_0001, 0, 1'b0, 64'h0);
        wq0.push_back(14'h0020);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 14'h0020, 64'hFFFF_EEEE_DDDD_CCCC);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 14'h0, 64'h0);
        chk("abort_busy_before", 1, 64'(busy0), 64'h1);
        @(negedge clk);
        rst_n = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        for (int k = 3; k < 6; k++) begin
            @(negedge clk);
            chk("abort_rdy", k, 64'(rdy0), 64'h0);
            chk("abort_busy", k, 64'(busy0), 64'h0);
            chk("abort_rd", k, rd0, 64'h0);
        end
        rst_n = 1'b1;
        txn(0, 1'b1, 1'b0, 14'h0020, 64'h0, 0, 1'b1, 64'h0BAD_F00D_CAFE_0001);

        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(1, 0));
            if ((sel == 0 ? wq0.size() : wq1.size()) == 0 || $urandom_range(1, 0) == 1) begin
                w = 1'b1;
                r = ($urandom_range(3, 0) == 0);
                a = 14'($urandom);
                d = {$urandom, $urandom};
                hold = 0;
                if (sel != 0) wq1.push_back(a); else wq0.push_back(a);
            end else begin
                w = 1'b0;
                r = 1'b1;
                d = {$urandom, $urandom};
                hold = int'($urandom_range(2, 0));
                if (sel != 0) begin
                    i = int'($urandom_range(wq1.size() - 1, 0));
                    a = (wq1[i] & 14'h000F) | (14'($urandom) & 14'h3FF0);
                end else begin
                    i = int'($urandom_range(wq0.size() - 1, 0));
                    a = wq0[i];
                end
            end
            txn(sel, r, w, a, d, hold, 1'b0, 64'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
